// File: rtl/reward_pkg.sv
// Shared types for the reward packer: packet and FBType codes,
// FSM states, and the fixed-priority trigger pick.
package reward_pkg;

    typedef enum logic [2:0] {
        PKT_HB   = 3'd0,
        PKT_CHE  = 3'd1,
        PKT_INV  = 3'd2,
        PKT_MR   = 3'd3,
        PKT_TS   = 3'd4,
        PKT_DATA = 3'd5,
        PKT_SOS  = 3'd6
    } pkt_type_e;

    typedef enum logic [2:0] {
        FB_HB_RIP  = 3'd0,
        FB_INV_RIP = 3'd1,
        FB_MR      = 3'd2,
        FB_FWD     = 3'd3,
        FB_OWN_INV = 3'd4,
        FB_TS      = 3'd5,
        FB_SRC     = 3'd6,
        FB_NONE    = 3'd7
    } fb_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PACK = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam logic [63:0] BROADCAST_ID = '1;

    // Forwarding beats own traffic, which beats rippling.
    function automatic fb_type_e pick_fb(input logic [6:0] p);
        if (p[3])      return FB_FWD;
        else if (p[6]) return FB_SRC;
        else if (p[5]) return FB_TS;
        else if (p[4]) return FB_OWN_INV;
        else if (p[2]) return FB_MR;
        else if (p[1]) return FB_INV_RIP;
        else if (p[0]) return FB_HB_RIP;
        else           return FB_NONE;
    endfunction

endpackage

// File: rtl/reward_packer_if.sv
// Packet bus from the reward packer to the CSMA/TDMA transmitter.
// valid/ready handshake; fields stay stable while valid is high.
interface reward_packer_if #(
    parameter int WORD_WIDTH = 16
);
    logic [WORD_WIDTH-1:0] rSourceID;
    logic [WORD_WIDTH-1:0] rEnergyLeft;
    logic [WORD_WIDTH-1:0] rQValue;
    logic [WORD_WIDTH-1:0] rSourceHops;
    logic [WORD_WIDTH-1:0] rDestinationID;
    logic [WORD_WIDTH-1:0] rPacketType;
    logic [WORD_WIDTH-1:0] rChosenCH;
    logic [WORD_WIDTH-1:0] rHopsFromCH;
    logic                  pkt_valid;
    logic                  pkt_ready;
    logic [2:0]            fbType;

    modport master (
        output rSourceID, rEnergyLeft, rQValue, rSourceHops,
        output rDestinationID, rPacketType, rChosenCH, rHopsFromCH,
        output pkt_valid, fbType,
        input  pkt_ready
    );

    modport slave (
        input  rSourceID, rEnergyLeft, rQValue, rSourceHops,
        input  rDestinationID, rPacketType, rChosenCH, rHopsFromCH,
        input  pkt_valid, fbType,
        output pkt_ready
    );
endinterface

// File: rtl/reward_timer.sv
// Down-counting timeout: load wins over clear, counting stops at 0,
// expire_pulse flags the tick that takes the count from 1 to 0.
module reward_timer #(
    parameter int WORD_WIDTH = 16,
    parameter int LOAD       = 10
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  load,
    input  logic                  tick,
    input  logic                  clr,
    output logic [WORD_WIDTH-1:0] count,
    output logic                  expire_pulse
);

    assign expire_pulse = tick & ~load & ~clr &
                          (count == WORD_WIDTH'(1));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            count <= '0;
        end else if (load) begin
            count <= WORD_WIDTH'(LOAD);
        end else if (clr) begin
            count <= '0;
        end else if (tick && count != '0) begin
            count <= count - WORD_WIDTH'(1);
        end
    end

endmodule

// File: rtl/reward_packer.sv
// Reward packer: latches send triggers into a pending set, picks one
// by fixed priority and presents it to the transmitter over valid/ready.
module reward_packer
    import reward_pkg::*;
#(
    parameter int WORD_WIDTH   = 16,
    parameter int MAX_INV_HOPS = 4,
    parameter int MR_TIMEOUT   = 10,
    parameter int TS_TIMEOUT   = 10,
    parameter int SINK_ID      = 0
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  en,
    input  logic [2:0]            fPacketType,
    input  logic                  iAmDestination,
    input  logic                  role,
    input  logic                  sendData,
    input  logic                  tick,
    input  logic                  round_clr,
    input  logic [WORD_WIDTH-1:0] myNodeID,
    input  logic [WORD_WIDTH-1:0] hopsFromSink,
    input  logic [WORD_WIDTH-1:0] myQValue,
    input  logic [WORD_WIDTH-1:0] myEnergy,
    input  logic [WORD_WIDTH-1:0] chosenCH,
    input  logic [WORD_WIDTH-1:0] hopsFromCH,
    input  logic [WORD_WIDTH-1:0] mNodeID,
    output logic                  busy,
    reward_packer_if.master       pkt
);

    localparam logic [WORD_WIDTH-1:0] BCAST = WORD_WIDTH'(BROADCAST_ID);
    localparam logic [WORD_WIDTH-1:0] SINK  = WORD_WIDTH'(SINK_ID);

    function automatic logic [WORD_WIDTH-1:0] ext(input logic [2:0] t);
        return WORD_WIDTH'(t);
    endfunction

    state_e                state_q, state_nxt;
    logic [6:0]            pending_q, pending_nxt;
    logic [6:0]            set_vec, clr_mask;
    fb_type_e              sel, fb_q;
    logic                  hb_lock_q, inv_lock_q, role_q;
    logic                  hb_lock_eff, inv_lock_eff;
    logic                  t_hb, t_inv, t_fwd, t_own;
    logic [2:0]            fwd_type_q;
    logic                  mr_load, mr_expire, ts_load, ts_expire;
    logic                  accept;
    logic [WORD_WIDTH-1:0] mr_count;
    logic [WORD_WIDTH-1:0] ts_count_unused;

    logic [WORD_WIDTH-1:0] src_q, nrg_q, qv_q, shops_q;
    logic [WORD_WIDTH-1:0] dst_q, ptype_q, ch_q, hch_q;

    // round_clr releases the locks before this cycle's triggers look at them
    assign hb_lock_eff  = hb_lock_q & ~round_clr;
    assign inv_lock_eff = inv_lock_q & ~round_clr;

    assign t_hb  = en & (fPacketType == PKT_HB) & ~hb_lock_eff;
    assign t_inv = en & (fPacketType == PKT_INV) & ~role &
                   (hopsFromCH < WORD_WIDTH'(MAX_INV_HOPS)) &
                   ~inv_lock_eff;
    assign t_fwd = en & iAmDestination &
                   ((fPacketType == PKT_DATA) |
                    (fPacketType == PKT_SOS));
    assign t_own = role & ~role_q;

    assign accept  = (state_q == ST_HOLD) & pkt.pkt_ready;
    assign mr_load = t_inv & ((mr_count == '0) | round_clr);
    assign ts_load = accept & (fb_q == FB_OWN_INV);

    assign set_vec = {sendData, ts_expire, t_own, t_fwd,
                      mr_expire, t_inv, t_hb};

    reward_timer #(
        .WORD_WIDTH (WORD_WIDTH),
        .LOAD       (MR_TIMEOUT)
    ) u_mr_timer (
        .clk          (clk),
        .nrst         (nrst),
        .load         (mr_load),
        .tick         (tick),
        .clr          (round_clr),
        .count        (mr_count),
        .expire_pulse (mr_expire)
    );

    reward_timer #(
        .WORD_WIDTH (WORD_WIDTH),
        .LOAD       (TS_TIMEOUT)
    ) u_ts_timer (
        .clk          (clk),
        .nrst         (nrst),
        .load         (ts_load),
        .tick         (tick),
        .clr          (round_clr),
        .count        (ts_count_unused),
        .expire_pulse (ts_expire)
    );

    assign sel = pick_fb(pending_q);

    always_comb begin
        clr_mask = '0;
        if (state_q == ST_PACK) begin
            clr_mask = 7'(1) << sel;
        end
        // a trigger landing on the bit being packed survives the clear
        pending_nxt = (pending_q & ~clr_mask) | set_vec;
    end

    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if ((pending_q | set_vec) != '0) state_nxt = ST_PACK;
            end
            ST_PACK: state_nxt = ST_HOLD;
            ST_HOLD: begin
                if (pkt.pkt_ready) begin
                    if ((pending_q | set_vec) != '0) begin
                        state_nxt = ST_PACK;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            hb_lock_q  <= 1'b0;
            inv_lock_q <= 1'b0;
            role_q     <= 1'b0;
            fwd_type_q <= PKT_DATA;
        end else begin
            state_q    <= state_nxt;
            pending_q  <= pending_nxt;
            hb_lock_q  <= hb_lock_eff | t_hb;
            inv_lock_q <= inv_lock_eff | t_inv;
            role_q     <= role;
            if (t_fwd && (!pending_q[3] || clr_mask[3])) begin
                fwd_type_q <= fPacketType;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            src_q   <= '0;
            nrg_q   <= '0;
            qv_q    <= '0;
            shops_q <= '0;
            dst_q   <= '0;
            ptype_q <= '0;
            ch_q    <= '0;
            hch_q   <= '0;
            fb_q    <= FB_NONE;
        end else if (state_q == ST_PACK) begin
            src_q   <= myNodeID;
            nrg_q   <= myEnergy;
            qv_q    <= myQValue;
            shops_q <= hopsFromSink;
            ch_q    <= chosenCH;
            hch_q   <= '0;
            fb_q    <= sel;
            unique case (sel)
                FB_HB_RIP: begin
                    ptype_q <= ext(PKT_HB);
                    dst_q   <= SINK;
                end
                FB_INV_RIP: begin
                    ptype_q <= ext(PKT_INV);
                    dst_q   <= BCAST;
                    hch_q   <= hopsFromCH + WORD_WIDTH'(1);
                end
                FB_MR: begin
                    ptype_q <= ext(PKT_MR);
                    dst_q   <= chosenCH;
                    hch_q   <= hopsFromCH;
                end
                FB_FWD: begin
                    ptype_q <= ext(fwd_type_q);
                    dst_q   <= mNodeID;
                end
                FB_OWN_INV: begin
                    ptype_q <= ext(PKT_INV);
                    dst_q   <= BCAST;
                    ch_q    <= myNodeID;
                end
                FB_TS: begin
                    ptype_q <= ext(PKT_TS);
                    dst_q   <= BCAST;
                    ch_q    <= myNodeID;
                end
                FB_SRC: begin
                    ptype_q <= ext(PKT_DATA);
                    dst_q   <= SINK;
                end
                default: begin
                    ptype_q <= '0;
                    dst_q   <= '0;
                end
            endcase
        end else if (accept) begin
            fb_q <= FB_NONE;
        end
    end

    assign pkt.rSourceID      = src_q;
    assign pkt.rEnergyLeft    = nrg_q;
    assign pkt.rQValue        = qv_q;
    assign pkt.rSourceHops    = shops_q;
    assign pkt.rDestinationID = dst_q;
    assign pkt.rPacketType    = ptype_q;
    assign pkt.rChosenCH      = ch_q;
    assign pkt.rHopsFromCH    = hch_q;
    assign pkt.pkt_valid      = (state_q == ST_HOLD);
    assign pkt.fbType         = fb_q;
    assign busy               = (state_q != ST_IDLE);

endmodule

// File: tb/tb_reward_packer.sv
// Scoreboard bench for reward_packer: expected packets are queued at
// stimulus time and compared when the transmitter side accepts them.
module tb_reward_packer;
    import reward_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         nrst = 1'b1;
    logic         en, iAmDestination, role, sendData, tick, round_clr;
    logic [2:0]   fPacketType;
    logic [W-1:0] myNodeID, hopsFromSink, myQValue, myEnergy;
    logic [W-1:0] chosenCH, hopsFromCH, mNodeID;
    logic         busy;

    typedef struct {
        logic [2:0]   fb;
        logic [W-1:0] ptype;
        logic [W-1:0] dest;
        logic [W-1:0] ch;
        logic [W-1:0] hch;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   n_rx = 0;
    int   rx0;

    reward_packer_if #(.WORD_WIDTH(W)) pif ();

    reward_packer #(
        .WORD_WIDTH   (W),
        .MAX_INV_HOPS (4),
        .MR_TIMEOUT   (10),
        .TS_TIMEOUT   (10),
        .SINK_ID      (0)
    ) dut (
        .clk            (clk),
        .nrst           (nrst),
        .en             (en),
        .fPacketType    (fPacketType),
        .iAmDestination (iAmDestination),
        .role           (role),
        .sendData       (sendData),
        .tick           (tick),
        .round_clr      (round_clr),
        .myNodeID       (myNodeID),
        .hopsFromSink   (hopsFromSink),
        .myQValue       (myQValue),
        .myEnergy       (myEnergy),
        .chosenCH       (chosenCH),
        .hopsFromCH     (hopsFromCH),
        .mNodeID        (mNodeID),
        .busy           (busy),
        .pkt            (pif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] fb,
                                input logic [W-1:0] pt,
                                input logic [W-1:0] dest,
                                input logic [W-1:0] ch,
                                input logic [W-1:0] hch);
        exp_t e;
        e.fb = fb;
        e.ptype = pt;
        e.dest = dest;
        e.ch = ch;
        e.hch = hch;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rx_pkt(input logic [2:0] t);
        en = 1'b1;
        fPacketType = t;
        step();
        en = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            step();
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((sb.size() != 0 || busy) && k < 60) begin
            step();
            k++;
        end
        if (k >= 60) chk("drain_timeout", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (nrst && pif.pkt_valid && pif.pkt_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_pkt", 32'(pif.fbType), 32'd7);
            end else begin
                e = sb.pop_front();
                chk("pkt_fb", 32'(pif.fbType), 32'(e.fb));
                chk("pkt_type", pif.rPacketType, e.ptype);
                chk("pkt_dest", pif.rDestinationID, e.dest);
                chk("pkt_ch", pif.rChosenCH, e.ch);
                chk("pkt_hch", pif.rHopsFromCH, e.hch);
                chk("pkt_src", pif.rSourceID, 16'h0011);
                chk("pkt_nrg", pif.rEnergyLeft, 16'h0777);
                chk("pkt_shops", pif.rSourceHops, 16'd3);
                n_rx++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        en = 1'b0;
        fPacketType = 3'd0;
        iAmDestination = 1'b0;
        role = 1'b0;
        sendData = 1'b0;
        tick = 1'b0;
        round_clr = 1'b0;
        myNodeID = 16'h0011;
        hopsFromSink = 16'd3;
        myQValue = 16'h0055;
        myEnergy = 16'h0777;
        chosenCH = 16'h0022;
        hopsFromCH = 16'd3;
        mNodeID = 16'h0033;
        pif.pkt_ready = 1'b1;

        #3 nrst = 1'b0;
        #4;
        chk("rst_valid", 32'(pif.pkt_valid), 0);
        chk("rst_fb", 32'(pif.fbType), 7);
        chk("rst_src", pif.rSourceID, 0);
        chk("rst_busy", 32'(busy), 0);
        step();
        step();
        nrst = 1'b1;
        step();
        step();

        // HB ripple, latency, then duplicate lock
        sb.push_back(mk(3'd0, 16'd0, 16'd0, 16'h0022, 16'd0));
        rx_pkt(PKT_HB);
        chk("hb_lat1", 32'(pif.pkt_valid), 0);
        step();
        chk("hb_lat2", 32'(pif.pkt_valid), 1);
        drain();
        rx0 = n_rx;
        rx_pkt(PKT_HB);
        repeat (6) step();
        chk("hb_dup", n_rx, rx0);
        round_clr = 1'b1;
        step();
        round_clr = 1'b0;
        sb.push_back(mk(3'd0, 16'd0, 16'd0, 16'h0022, 16'd0));
        rx_pkt(PKT_HB);
        drain();
        chk("hb_after_clr", n_rx, rx0 + 1);

        // INV ripple then MR after 10 ticks
        sb.push_back(mk(3'd1, 16'd2, 16'hFFFF, 16'h0022, 16'd4));
        rx_pkt(PKT_INV);
        drain();
        rx0 = n_rx;
        ticks(9);
        repeat (4) step();
        chk("mr_early", n_rx, rx0);
        sb.push_back(mk(3'd2, 16'd3, 16'h0022, 16'h0022, 16'd3));
        ticks(1);
        drain();
        chk("mr_sent", n_rx, rx0 + 1);

        // INV at the hop limit is dropped
        round_clr = 1'b1;
        step();
        round_clr = 1'b0;
        hopsFromCH = 16'd4;
        rx0 = n_rx;
        rx_pkt(PKT_INV);
        repeat (6) step();
        chk("inv_hops4", n_rx, rx0);
        chk("inv_hops4_busy", 32'(busy), 0);
        hopsFromCH = 16'd3;

        // own INV held under backpressure, then TS
        pif.pkt_ready = 1'b0;
        sb.push_back(mk(3'd4, 16'd2, 16'hFFFF, 16'h0011, 16'd0));
        role = 1'b1;
        step();
        step();
        repeat (5) begin
            chk("own_hold_valid", 32'(pif.pkt_valid), 1);
            chk("own_hold_fb", 32'(pif.fbType), 4);
            chk("own_hold_ch", pif.rChosenCH, 16'h0011);
            chk("own_hold_dst", pif.rDestinationID, 16'hFFFF);
            step();
        end
        pif.pkt_ready = 1'b1;
        drain();
        rx0 = n_rx;
        ticks(9);
        repeat (4) step();
        chk("ts_early", n_rx, rx0);
        sb.push_back(mk(3'd5, 16'd4, 16'hFFFF, 16'h0011, 16'd0));
        ticks(1);
        drain();
        chk("ts_sent", n_rx, rx0 + 1);
        role = 1'b0;
        step();

        // SOS forward beats same-cycle source data
        rx0 = n_rx;
        sb.push_back(mk(3'd3, 16'd6, 16'h0033, 16'h0022, 16'd0));
        sb.push_back(mk(3'd6, 16'd5, 16'd0, 16'h0022, 16'd0));
        en = 1'b1;
        fPacketType = PKT_SOS;
        iAmDestination = 1'b1;
        sendData = 1'b1;
        step();
        en = 1'b0;
        iAmDestination = 1'b0;
        sendData = 1'b0;
        drain();
        chk("fwd_then_src", n_rx, rx0 + 2);

        // reset while holding a packet
        pif.pkt_ready = 1'b0;
        sendData = 1'b1;
        step();
        sendData = 1'b0;
        step();
        chk("rst_pre_valid", 32'(pif.pkt_valid), 1);
        nrst = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(pif.pkt_valid), 0);
        chk("rst_mid_fb", 32'(pif.fbType), 7);
        chk("rst_mid_src", pif.rSourceID, 0);
        chk("rst_mid_dst", pif.rDestinationID, 0);
        chk("rst_mid_type", pif.rPacketType, 0);
        chk("rst_mid_busy", 32'(busy), 0);
        step();
        nrst = 1'b1;
        pif.pkt_ready = 1'b1;
        rx0 = n_rx;
        repeat (10) step();
        chk("rst_no_residual", n_rx, rx0);
        chk("rst_idle_busy", 32'(busy), 0);

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
